// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM controller arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic PORT_0 = 1'b0;
  localparam logic PORT_1 = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYC = 31;

  // Wide enough for the largest allowed timeout (255).
  localparam int CNT_W = 8;

endpackage

// File: rtl/sram_arb_picker.sv
// Combinational grant selection between the two requesters.
// Define SRAM_ARB_RR_EN to alternate on simultaneous requests; otherwise
// port 0 has fixed priority and last_served is ignored.
module sram_arb_picker
  import sram_arb_pkg::*;
(
  input  logic req_0,
  input  logic req_1,
  input  logic last_served,
  output logic winner,
  output logic valid
);

`ifndef SRAM_ARB_RR_EN
  logic unused_last_served;
  assign unused_last_served = last_served;
`endif

  // Pick the port to grant; valid whenever anyone is asking.
  always_comb begin
    valid  = req_0 | req_1;
    winner = PORT_0;
`ifdef SRAM_ARB_RR_EN
    if (req_0 && req_1) begin
      winner = (last_served == PORT_0) ? PORT_1 : PORT_0;
    end else if (req_1) begin
      winner = PORT_1;
    end
`else
    if (!req_0 && req_1) begin
      winner = PORT_1;
    end
`endif
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single SRAM controller.
// IDLE grants a requester, BUSY drives the controller until mem_ready (or
// timeout), RESP pulses done for one cycle. Optional round-robin on
// simultaneous requests is enabled with SRAM_ARB_RR_EN.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              we_0,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              done_0,
  output logic              done_1,
  output logic [DATA_W-1:0] rdata_0,
  output logic [DATA_W-1:0] rdata_1,
  output logic              stall_0,
  output logic              stall_1,
  output logic              err,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  // The counter value on the last allowed BUSY cycle; reaching it times out.
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_t       state;
  logic             cur_port;
  logic             cur_we;
  logic             last_served;
  logic [CNT_W-1:0] busy_cnt;
  logic             winner;
  logic             win_valid;

  sram_arb_picker u_picker (
    .req_0       (req_0),
    .req_1       (req_1),
    .last_served (last_served),
    .winner      (winner),
    .valid       (win_valid)
  );

  assign stall_0 = req_0 & ~done_0;
  assign stall_1 = req_1 & ~done_1;

  // Arbitration FSM with registered controller strobes and response pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_port    <= PORT_0;
      cur_we      <= 1'b0;
      last_served <= PORT_1;
      busy_cnt    <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata_0     <= '0;
      rdata_1     <= '0;
      done_0      <= 1'b0;
      done_1      <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state     <= BUSY;
            cur_port  <= winner;
            busy_cnt  <= '0;
            cur_we    <= (winner == PORT_1) ? we_1 : we_0;
            mem_we    <= (winner == PORT_1) ? we_1 : we_0;
            mem_re    <= (winner == PORT_1) ? ~we_1 : ~we_0;
            mem_addr  <= (winner == PORT_1) ? addr_1 : addr_0;
            mem_wdata <= (winner == PORT_1) ? wdata_1 : wdata_0;
`ifdef SRAM_ARB_RR_EN
            last_served <= winner;
`endif
          end
        end
        BUSY: begin
          if (mem_ready && (busy_cnt != '0)) begin
            state  <= RESP;
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            done_0 <= (cur_port == PORT_0);
            done_1 <= (cur_port == PORT_1);
            if (!cur_we) begin
              if (cur_port == PORT_0) begin
                rdata_0 <= mem_rdata;
              end else begin
                rdata_1 <= mem_rdata;
              end
            end
          end else if (busy_cnt == BUSY_LAST) begin
            state  <= RESP;
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            done_0 <= (cur_port == PORT_0);
            done_1 <= (cur_port == PORT_1);
            err    <= 1'b1;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        RESP: begin
          state  <= IDLE;
          done_0 <= 1'b0;
          done_1 <= 1'b0;
          err    <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a simple controller model whose
// ready rises 5 cycles after an enable asserts (or is tied low/high).
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_0, req_1, we_0, we_1;
  logic [31:0] addr_0, addr_1, wdata_0, wdata_1;
  logic        done_0, done_1, stall_0, stall_1, err;
  logic [31:0] rdata_0, rdata_1;
  logic        mem_we, mem_re, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] model_rdata[2];
  int          n_compared   = 0;
  int          n_mismatched = 0;
  int          cyc          = 0;
  int          ready_mode   = 0;
  logic [7:0]  ctl_cnt      = 8'd0;

  sram_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_0     (req_0),
    .req_1     (req_1),
    .we_0      (we_0),
    .we_1      (we_1),
    .addr_0    (addr_0),
    .addr_1    (addr_1),
    .wdata_0   (wdata_0),
    .wdata_1   (wdata_1),
    .done_0    (done_0),
    .done_1    (done_1),
    .rdata_0   (rdata_0),
    .rdata_1   (rdata_1),
    .stall_0   (stall_0),
    .stall_1   (stall_1),
    .err       (err),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memModel(input logic [31:0] a);
    return (a == 32'h400) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  // Controller model: cycles since an enable went high, plus read data.
  always @(posedge clk) ctl_cnt <= (mem_re | mem_we) ? ctl_cnt + 8'd1 : 8'd0;

  always_comb begin
    mem_rdata = memModel(mem_addr);
    case (ready_mode)
      1:       mem_ready = 1'b0;
      2:       mem_ready = 1'b1;
      default: mem_ready = (mem_re | mem_we) && (ctl_cnt >= 8'd5);
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic pushExpect(input int port, input logic we, input logic [31:0] addr, input logic exp_err);
    if (!we && !exp_err) model_rdata[port] = memModel(addr);
    exp_q.push_back('{port, exp_err, model_rdata[port]});
  endtask

  task automatic applyStimulus(input int port, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit push_exp, input logic exp_err);
    if (port == 0) begin
      we_0 = we; addr_0 = addr; wdata_0 = wdata; req_0 = 1'b1;
    end else begin
      we_1 = we; addr_1 = addr; wdata_1 = wdata; req_1 = 1'b1;
    end
    if (push_exp) pushExpect(port, we, addr, exp_err);
  endtask

  task automatic waitDone(input int port, input int start, input int max_cyc,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          output int lat, output int re_cnt, output int we_cnt);
    int bad_addr = 0;
    int bad_wdata = 0;
    lat = -1; re_cnt = 0; we_cnt = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (mem_re) re_cnt++;
      if (mem_we) we_cnt++;
      if ((mem_re || mem_we) && mem_addr !== exp_addr) bad_addr++;
      if (mem_we && mem_wdata !== exp_wdata) bad_wdata++;
      if ((port == 0 && done_0) || (port == 1 && done_1)) begin
        lat = cyc - start;
        break;
      end
    end
    if (lat < 0) checkOutput("done_wait_expired", 32'd0, 32'd1);
    checkOutput("mem_addr_busy_bad_cycles", bad_addr, 0);
    checkOutput("mem_wdata_busy_bad_cycles", bad_wdata, 0);
    checkOutput("stall_at_done", (port == 0) ? stall_0 : stall_1, 0);
    if (port == 0) req_0 = 1'b0; else req_1 = 1'b0;
  endtask

  // Monitor: every done pulse must match the next expected response.
  always @(negedge clk) begin
    if (!rst) begin
      if (done_0 && done_1) checkOutput("done_exclusive", 1, 0);
      if (err && !(done_0 || done_1)) checkOutput("err_without_done", 1, 0);
      if (done_0 || done_1) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done_port1", done_1, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("done_port", done_1, mon_e.port);
          checkOutput("err_flag", err, mon_e.err);
          checkOutput("rdata", (mon_e.port == 1) ? rdata_1 : rdata_0, mon_e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int start, lat, re_cnt, we_cnt, n0, act;
    int t[4];
    bit got;
    rst = 1'b1;
    req_0 = 0; req_1 = 0; we_0 = 0; we_1 = 0;
    addr_0 = 0; addr_1 = 0; wdata_0 = 0; wdata_1 = 0;
    model_rdata[0] = 0; model_rdata[1] = 0;
    for (int k = 0; k < 4; k++) t[k] = 0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_done_0", done_0, 0);
    checkOutput("rst_done_1", done_1, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_re", mem_re, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_rdata_0", rdata_0, 0);
    checkOutput("rst_rdata_1", rdata_1, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Port 0 read of 0x400
    $display("[TB] read port 0");
    start = cyc;
    applyStimulus(0, 1'b0, 32'h400, 32'h0, 1, 1'b0);
    #1 checkOutput("stall_0_waiting", stall_0, 1);
    waitDone(0, start, 20, 32'h400, 32'h0, lat, re_cnt, we_cnt);
    checkOutput("read_latency", lat, 7);
    checkOutput("read_mem_re_cycles", re_cnt, 6);
    checkOutput("read_mem_we_cycles", we_cnt, 0);
    repeat (2) @(negedge clk);

    // Port 1 write of 0x12345678 to 0x408
    $display("[TB] write port 1");
    start = cyc;
    applyStimulus(1, 1'b1, 32'h408, 32'h12345678, 1, 1'b0);
    waitDone(1, start, 20, 32'h408, 32'h12345678, lat, re_cnt, we_cnt);
    checkOutput("write_latency", lat, 7);
    checkOutput("write_mem_we_cycles", we_cnt, 6);
    checkOutput("write_mem_re_cycles", re_cnt, 0);
    repeat (2) @(negedge clk);

    // Simultaneous requests, port 0 wants three transactions
    $display("[TB] simultaneous requests");
    start = cyc;
    applyStimulus(0, 1'b0, 32'h100, 32'h0, 0, 1'b0);
    applyStimulus(1, 1'b0, 32'h200, 32'h0, 0, 1'b0);
`ifdef SRAM_ARB_RR_EN
    pushExpect(0, 1'b0, 32'h100, 1'b0);
    pushExpect(1, 1'b0, 32'h200, 1'b0);
    pushExpect(0, 1'b0, 32'h100, 1'b0);
    pushExpect(0, 1'b0, 32'h100, 1'b0);
`else
    pushExpect(0, 1'b0, 32'h100, 1'b0);
    pushExpect(0, 1'b0, 32'h100, 1'b0);
    pushExpect(0, 1'b0, 32'h100, 1'b0);
    pushExpect(1, 1'b0, 32'h200, 1'b0);
`endif
    n0 = 3;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (done_0 || done_1) got = 1;
      end
      if (!got) begin
        checkOutput("simul_done_expired", 0, 1);
        break;
      end
      t[k] = cyc;
      if (done_0) begin
        n0--;
        if (n0 == 0) req_0 = 1'b0;
      end
      if (done_1) req_1 = 1'b0;
    end
    req_0 = 1'b0; req_1 = 1'b0;
    checkOutput("simul_first_latency", t[0] - start, 7);
    for (int k = 1; k < 4; k++) checkOutput("simul_grant_spacing", t[k] - t[k-1], 8);
    repeat (2) @(negedge clk);

    // Controller never ready: timeout after 31 BUSY cycles
    $display("[TB] timeout");
    ready_mode = 1;
    start = cyc;
    applyStimulus(0, 1'b0, 32'h900, 32'h0, 1, 1'b1);
    waitDone(0, start, 60, 32'h900, 32'h0, lat, re_cnt, we_cnt);
    checkOutput("timeout_latency", lat, 32);
    checkOutput("timeout_busy_cycles", re_cnt, 31);
    ready_mode = 0;
    repeat (2) @(negedge clk);
    start = cyc;
    applyStimulus(1, 1'b0, 32'hA00, 32'h0, 1, 1'b0);
    waitDone(1, start, 20, 32'hA00, 32'h0, lat, re_cnt, we_cnt);
    checkOutput("post_timeout_latency", lat, 7);
    repeat (2) @(negedge clk);

    // Ready stuck high: ignored in IDLE and on the first BUSY cycle
    $display("[TB] ready stuck high");
    ready_mode = 2;
    repeat (3) @(negedge clk);
    start = cyc;
    applyStimulus(0, 1'b0, 32'h300, 32'h0, 1, 1'b0);
    waitDone(0, start, 20, 32'h300, 32'h0, lat, re_cnt, we_cnt);
    checkOutput("early_ready_latency", lat, 3);
    checkOutput("early_ready_re_cycles", re_cnt, 2);
    ready_mode = 0;
    repeat (2) @(negedge clk);

    // Port 0 request withdrawn while port 1 is being served
    $display("[TB] withdrawn request");
    start = cyc;
    applyStimulus(1, 1'b1, 32'h700, 32'hCAFE0001, 1, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(0, 1'b0, 32'h800, 32'h0, 0, 1'b0);
    #1 checkOutput("stall_0_while_other_busy", stall_0, 1);
    @(negedge clk);
    req_0 = 1'b0;
    waitDone(1, start, 20, 32'h700, 32'hCAFE0001, lat, re_cnt, we_cnt);
    checkOutput("withdraw_port1_latency", lat, 7);
    act = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_re || mem_we) act++;
    end
    checkOutput("withdraw_no_activity", act, 0);

    // Reset during the third BUSY cycle
    $display("[TB] reset mid-transaction");
    start = cyc;
    applyStimulus(1, 1'b0, 32'h500, 32'h0, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    req_1 = 1'b0;
    #1;
    checkOutput("midrst_mem_re", mem_re, 0);
    checkOutput("midrst_mem_addr", mem_addr, 0);
    checkOutput("midrst_rdata_0", rdata_0, 0);
    checkOutput("midrst_rdata_1", rdata_1, 0);
    checkOutput("midrst_done_1", done_1, 0);
    model_rdata[0] = 0; model_rdata[1] = 0;
    @(negedge clk);
    rst = 1'b0;
    act = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_re || mem_we || done_0 || done_1 || err) act++;
    end
    checkOutput("midrst_no_activity", act, 0);
    start = cyc;
    applyStimulus(0, 1'b0, 32'h600, 32'h0, 1, 1'b0);
    waitDone(0, start, 20, 32'h600, 32'h0, lat, re_cnt, we_cnt);
    checkOutput("post_reset_latency", lat, 7);
    repeat (3) @(negedge clk);

    checkOutput("scoreboard_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
